btb_nway: RTL and testbench
===========================

Name: btb_nway

Overview:
- Parametrised set-associative branch target buffer for the superscalar fetch stage.
- Serves FETCH_WIDTH instruction slots per fetch block, with one bank per slot and WAYS ways per set.
- Replacement is tree pseudo-LRU. Update hits overwrite the matching entry in place; they never duplicate it.
- A sequential init/flush sweep clears all sets after reset or on request. Lookup is combinational and feeds next-PC selection in the same cycle.

Parameters:
- FETCH_WIDTH, 4, slots (banks) per fetch block; power of two, 1..8.
- SETS, 32, sets per bank; power of two, 4..256.
- WAYS, 2, ways per set; 2 or 4.
- TAG_BITS, 10, stored tag width; 4..16.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- flush  in  1  one-cycle request to invalidate the whole BTB.
- ready  out  1  1 = sweep finished, lookups/updates live.
- fetch_pc  in  32  fetch block PC; bits [log2(FETCH_WIDTH)+1:0] ignored.
- lookup_valid  in  1  fetch_pc valid this cycle.
- inst_bj  in  FETCH_WIDTH  per-slot: predecoded branch/jump; gates LRU touch.
- hit  out  FETCH_WIDTH  per-slot hit.
- bta  out  32*FETCH_WIDTH  per-slot target; slot s at [32s+31:32s].
- btype  out  2*FETCH_WIDTH  per-slot type: 00 direct, 01 call, 10 return, 11 indirect.
- update_en  in  1  commit-time update strobe.
- update_pc  in  32  PC of the resolved branch.
- update_bta  in  32  resolved target.
- update_type  in  2  resolved type.

Behaviour:
- Address split, with B = log2(FETCH_WIDTH) and I = log2(SETS):
  - bank = pc[B+1:2].
  - index = pc[B+2+I-1:B+2].
  - tag = XOR-fold of pc[31:B+2+I] in TAG_BITS chunks, LSB-aligned, last chunk zero-extended.
  - At defaults: bank = pc[3:2], index = pc[8:4], tag = pc[18:9] ^ pc[28:19] ^ {7'b0, pc[31:29]}.
- Entry fields: valid, tag, bta[31:0], type[1:0]. Each (bank, set) also holds WAYS-1 pLRU bits.
- Lookup (combinational), slot s, bank s, index from fetch_pc:
  - hit[s] = ready & lookup_valid & any way valid with a matching tag.
  - If several ways match, the lowest way index wins.
  - On hit, bta/btype come from the matched way.
  - On miss, bta = {fetch_pc[31:B+2], (B+2)'b0} + 4*(s+1) and btype = 00.
- LRU touch: at the clock edge, each slot with hit[s] & inst_bj[s] marks its hit way most-recently-used. All slots touch in parallel, since each uses a distinct bank.
- Update (clock edge, when ready & update_en), in bank/set/tag from update_pc:
  - If a valid way matches the tag, overwrite bta/type in that way.
  - Otherwise write the lowest-indexed invalid way.
  - Otherwise write the pLRU victim.
  - The written entry gets valid = 1, and that way is touched MRU.
- Simultaneous update and lookup-touch on the same bank/set: the update's MRU write wins.
- Lookups in the update cycle see pre-update contents; the new entry is visible from the next cycle.
- Update and lookup of different banks are fully independent.
- FSM has two states, INIT and READY, plus a set counter ctr of width I.
  - resetn = 0 at an edge: state <= INIT, ctr <= 0, ready <= 0.
  - In INIT, each edge clears valid and pLRU for set ctr in all banks and ways, then ctr++.
  - In INIT with ctr == SETS-1, the edge moves to READY; ready = 1 exactly SETS edges after the first edge with resetn = 1.
  - In READY, flush = 1 gives INIT with ctr = 0 and ready = 0 next cycle. A lookup in the flush cycle still returns the old contents.
  - A flush during INIT restarts ctr at 0. A reset mid-sweep also restarts.
  - update_en while not ready is dropped with no effect. lookup_valid while not ready gives all hit = 0 and fall-through bta.
- Reset output values: ready = 0; hit = 0; bta = per-slot fall-through of fetch_pc; btype = 0.
- Arithmetic: the fall-through add is 32-bit and wraps modulo 2^32 (e.g., block 0xFFFFFFF0, slot 3 gives 0x00000000).

Test Plan:
- Reset, then release resetn -> ready = 0 for 32 cycles, then 1. Any lookup during the sweep -> hit = 0, bta = fall-through (fetch_pc 0x1000: 0x1004, 0x1008, 0x100C, 0x1010).
- Update pc 0x0000_1008, bta 0x2000, type 01. Next cycle, lookup fetch_pc 0x1000 -> hit = 0100, slot 2 bta 0x2000, btype 01. Slots 0, 1, 3 -> fall-through.
- Update 0x1008 three times with distinct tags (0x0000_1008, 0x0000_3008, 0x0000_5008), inst_bj touching tag 0x1008 after the second update -> third update evicts 0x3008. 0x1008 and 0x5008 hit; 0x3008 misses.
- Update 0x1008 bta 0x2000, then 0x1008 bta 0x4000 -> single entry holding 0x4000. A further update with a new tag still finds the other way invalid and fills it, with no eviction.
- Fill several entries, pulse flush for 1 cycle -> ready low for 32 cycles, all lookups miss afterward. A second flush at sweep cycle 10 extends ready-low to 32 cycles from that pulse.
- Same-cycle update_en and lookup on the same bank/set with a new tag -> lookup reports the old state. The new entry hits next cycle. The pLRU victim on a following conflicting update is the non-updated way.

Source files
------------

// File: rtl/btb_nway.sv
// btb_nway: set-associative branch target buffer for the superscalar fetch stage.
//
// Each fetch block holds FETCH_WIDTH instruction slots. Slot s is served only
// by bank s, so all slots look up in parallel. Each bank has SETS sets of WAYS
// ways, and each set has a tree pseudo-LRU. After reset or a flush, a
// sequential sweep clears one set per cycle in every bank. Lookups and updates
// are live only while ready is high.
//
// Ports:
//   clk          clock
//   resetn       synchronous active-low reset (restarts the sweep)
//   flush        one-cycle request to invalidate the whole BTB
//   ready        1 = sweep finished, lookups/updates live
//   fetch_pc     fetch block PC (bits [log2(FETCH_WIDTH)+1:0] ignored)
//   lookup_valid fetch_pc valid this cycle
//   inst_bj      per-slot predecoded branch/jump, gates the LRU touch
//   hit          per-slot hit
//   bta          per-slot target, slot s at [32s+31:32s]
//   btype        per-slot type: 00 direct, 01 call, 10 return, 11 indirect
//   update_en    commit-time update strobe
//   update_pc    PC of the resolved branch
//   update_bta   resolved target
//   update_type  resolved type
module btb_nway #(
  parameter int FETCH_WIDTH = 4,
  parameter int SETS        = 32,
  parameter int WAYS        = 2,
  parameter int TAG_BITS    = 10
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  output logic                     ready,
  input  logic [31:0]              fetch_pc,
  input  logic                     lookup_valid,
  input  logic [FETCH_WIDTH-1:0]   inst_bj,
  output logic [FETCH_WIDTH-1:0]   hit,
  output logic [32*FETCH_WIDTH-1:0] bta,
  output logic [2*FETCH_WIDTH-1:0] btype,
  input  logic                     update_en,
  input  logic [31:0]              update_pc,
  input  logic [31:0]              update_bta,
  input  logic [1:0]               update_type
);

  localparam int B       = $clog2(FETCH_WIDTH);
  localparam int I       = $clog2(SETS);
  localparam int WAY_W   = $clog2(WAYS);
  localparam int PW      = WAYS - 1;
  localparam int BANK_W  = (B > 0) ? B : 1;
  localparam int TAG_LSB = B + 2 + I;
  localparam int NCHUNK  = (32 - TAG_LSB + TAG_BITS - 1) / TAG_BITS;
  localparam logic [31:0] BLOCK_MASK = ~((32'd1 << (B + 2)) - 32'd1);

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t r_state;
  state_t w_stateNext;
  logic [I-1:0] r_ctr;
  logic [I-1:0] w_ctrNext;

  logic                r_valid [FETCH_WIDTH][SETS][WAYS];
  logic [TAG_BITS-1:0] r_tag   [FETCH_WIDTH][SETS][WAYS];
  logic [31:0]         r_bta   [FETCH_WIDTH][SETS][WAYS];
  logic [1:0]          r_type  [FETCH_WIDTH][SETS][WAYS];
  logic [PW-1:0]       r_plru  [FETCH_WIDTH][SETS];

  logic [I-1:0]        w_lkIdx;
  logic [TAG_BITS-1:0] w_lkTag;
  logic [31:0]         w_blockBase;
  logic [FETCH_WIDTH-1:0] w_lkAny;
  logic [WAY_W-1:0]    w_lkWay [FETCH_WIDTH];

  logic [BANK_W-1:0]   w_upBank;
  logic [I-1:0]        w_upIdx;
  logic [TAG_BITS-1:0] w_upTag;
  logic                w_upHit;
  logic [WAY_W-1:0]    w_upHitWay;
  logic                w_upFree;
  logic [WAY_W-1:0]    w_upFreeWay;
  logic [WAY_W-1:0]    w_upWay;
  logic                w_upWrite;

  // The upper PC bits are XOR-folded into TAG_BITS chunks, LSB-aligned; the
  // shift leaves zeros above bit 31, which zero-extends the last chunk.
  function automatic logic [TAG_BITS-1:0] foldTag(input logic [31:0] pc);
    logic [31:0]         upper;
    logic [TAG_BITS-1:0] t;
    upper = pc >> TAG_LSB;
    t = '0;
    for (int c = 0; c < NCHUNK; c++) begin
      t = t ^ TAG_BITS'(upper >> (c * TAG_BITS));
    end
    return t;
  endfunction

  // The pLRU tree is stored heap-style (node n has children 2n+1, 2n+2).
  // A node bit points toward the half that holds the victim (0 = lower
  // ways). A touch makes every node on the path point away from the way.
  function automatic logic [PW-1:0] plruTouch(input logic [PW-1:0] cur,
                                               input logic [WAY_W-1:0] way);
    logic [PW-1:0] nxt;
    logic [PW-1:0] m;
    logic          b;
    int            node;
    nxt  = cur;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b    = 1'(way >> (WAY_W - 1 - l));
      m    = PW'(1) << node;
      nxt  = b ? (nxt & ~m) : (nxt | m);
      node = 2 * node + (b ? 2 : 1);
    end
    return nxt;
  endfunction

  function automatic logic [WAY_W-1:0] plruVictim(input logic [PW-1:0] cur);
    logic [WAY_W-1:0] w;
    logic             b;
    int               node;
    w    = '0;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b    = |(cur & (PW'(1) << node));
      w    = WAY_W'({w, b});
      node = 2 * node + (b ? 2 : 1);
    end
    return w;
  endfunction

  assign ready       = (r_state == S_READY);
  assign w_lkIdx     = fetch_pc[TAG_LSB-1:B+2];
  assign w_lkTag     = foldTag(fetch_pc);
  assign w_blockBase = fetch_pc & BLOCK_MASK;
  assign w_upBank    = BANK_W'((update_pc >> 2) & 32'(FETCH_WIDTH - 1));
  assign w_upIdx     = update_pc[TAG_LSB-1:B+2];
  assign w_upTag     = foldTag(update_pc);
  assign w_upWrite   = resetn & ready & update_en;

  // Sweep/ready state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_INIT;
      r_ctr   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_ctr   <= w_ctrNext;
    end
  end

  // A flush in either state restarts the sweep from set 0.
  always_comb begin
    w_stateNext = r_state;
    w_ctrNext   = r_ctr;
    case (r_state)
      S_INIT: begin
        if (flush) begin
          w_ctrNext = '0;
        end else if (r_ctr == I'(SETS - 1)) begin
          w_stateNext = S_READY;
          w_ctrNext   = '0;
        end else begin
          w_ctrNext = r_ctr + 1'b1;
        end
      end
      S_READY: begin
        if (flush) begin
          w_stateNext = S_INIT;
          w_ctrNext   = '0;
        end
      end
      default: begin
        w_stateNext = S_INIT;
        w_ctrNext   = '0;
      end
    endcase
  end

  // Per-slot lookup. Ways are scanned from the top down, so the lowest
  // matching way is the one left selected.
  always_comb begin
    hit     = '0;
    bta     = '0;
    btype   = '0;
    w_lkAny = '0;
    for (int s = 0; s < FETCH_WIDTH; s++) begin
      w_lkWay[s] = '0;
    end
    for (int s = 0; s < FETCH_WIDTH; s++) begin
      for (int w = WAYS - 1; w >= 0; w--) begin
        if (r_valid[s][w_lkIdx][w] && (r_tag[s][w_lkIdx][w] == w_lkTag)) begin
          w_lkAny[s] = 1'b1;
          w_lkWay[s] = WAY_W'(w);
        end
      end
      hit[s] = ready & lookup_valid & w_lkAny[s];
      if (hit[s]) begin
        bta[32*s +: 32]  = r_bta[s][w_lkIdx][w_lkWay[s]];
        btype[2*s +: 2]  = r_type[s][w_lkIdx][w_lkWay[s]];
      end else begin
        bta[32*s +: 32]  = w_blockBase + 32'(4 * (s + 1));
      end
    end
  end

  // Update way choice: matching way, else lowest invalid way, else pLRU victim.
  always_comb begin
    w_upHit     = 1'b0;
    w_upHitWay  = '0;
    w_upFree    = 1'b0;
    w_upFreeWay = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_upBank][w_upIdx][w] && (r_tag[w_upBank][w_upIdx][w] == w_upTag)) begin
        w_upHit    = 1'b1;
        w_upHitWay = WAY_W'(w);
      end
      if (!r_valid[w_upBank][w_upIdx][w]) begin
        w_upFree    = 1'b1;
        w_upFreeWay = WAY_W'(w);
      end
    end
    if (w_upHit) begin
      w_upWay = w_upHitWay;
    end else if (w_upFree) begin
      w_upWay = w_upFreeWay;
    end else begin
      w_upWay = plruVictim(r_plru[w_upBank][w_upIdx]);
    end
  end

  // Storage. The update's pLRU write is issued after the lookup touches so
  // that it wins when both land on the same bank/set.
  always_ff @(posedge clk) begin
    if (r_state == S_INIT) begin
      for (int s = 0; s < FETCH_WIDTH; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][r_ctr][w] <= 1'b0;
        end
        r_plru[s][r_ctr] <= '0;
      end
    end else if (resetn) begin
      for (int s = 0; s < FETCH_WIDTH; s++) begin
        if (hit[s] && inst_bj[s]) begin
          r_plru[s][w_lkIdx] <= plruTouch(r_plru[s][w_lkIdx], w_lkWay[s]);
        end
      end
      if (w_upWrite) begin
        r_valid[w_upBank][w_upIdx][w_upWay] <= 1'b1;
        r_tag[w_upBank][w_upIdx][w_upWay]   <= w_upTag;
        r_bta[w_upBank][w_upIdx][w_upWay]   <= update_bta;
        r_type[w_upBank][w_upIdx][w_upWay]  <= update_type;
        r_plru[w_upBank][w_upIdx]           <= plruTouch(r_plru[w_upBank][w_upIdx], w_upWay);
      end
    end
  end

endmodule

// File: tb/tb_btb_nway.sv
// Directed testbench for btb_nway at default parameters (4 slots, 32 sets,
// 2 ways, 10-bit tags). Inputs change 1 ns after each rising edge and outputs
// are compared before the next rising edge.
module tb_btb_nway;

  logic         clk = 1'b0;
  logic         resetn;
  logic         flush;
  logic         ready;
  logic [31:0]  fetch_pc;
  logic         lookup_valid;
  logic [3:0]   inst_bj;
  logic [3:0]   hit;
  logic [127:0] bta;
  logic [7:0]   btype;
  logic         update_en;
  logic [31:0]  update_pc;
  logic [31:0]  update_bta;
  logic [1:0]   update_type;

  int nCompared   = 0;
  int nMismatched = 0;
  int n;

  btb_nway #(
    .FETCH_WIDTH(4),
    .SETS(32),
    .WAYS(2),
    .TAG_BITS(10)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .flush(flush),
    .ready(ready),
    .fetch_pc(fetch_pc),
    .lookup_valid(lookup_valid),
    .inst_bj(inst_bj),
    .hit(hit),
    .bta(bta),
    .btype(btype),
    .update_en(update_en),
    .update_pc(update_pc),
    .update_bta(update_bta),
    .update_type(update_type)
  );

  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", name, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input logic lv, input logic [3:0] bj);
    fetch_pc     = pc;
    lookup_valid = lv;
    inst_bj      = bj;
    #1;
  endtask

  task automatic checkSlot(input string name, input int s, input logic expHit,
                           input logic [31:0] expBta, input logic [1:0] expType);
    checkOutput({name, "_hit"},  32'(hit >> s) & 32'h1, 32'(expHit));
    checkOutput({name, "_bta"},  32'(bta >> (32 * s)), expBta);
    checkOutput({name, "_type"}, 32'(btype >> (2 * s)) & 32'h3, 32'(expType));
  endtask

  task automatic doUpdate(input logic [31:0] pc, input logic [31:0] target, input logic [1:0] ty);
    update_pc   = pc;
    update_bta  = target;
    update_type = ty;
    update_en   = 1'b1;
    tick();
    update_en   = 1'b0;
  endtask

  task automatic countSweep(output int cycles);
    cycles = 0;
    while (ready !== 1'b1 && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; fetch_pc = '0; lookup_valid = 1'b0; inst_bj = '0;
    update_en = 1'b0; update_pc = '0; update_bta = '0; update_type = '0;
    repeat (2) tick();

    checkOutput("reset_ready", 32'(ready), 32'd0);
    applyStimulus(32'h0000_1000, 1'b1, 4'b0000);
    checkOutput("reset_hit", 32'(hit), 32'd0);
    checkSlot("reset_s0", 0, 1'b0, 32'h0000_1004, 2'b00);
    checkSlot("reset_s1", 1, 1'b0, 32'h0000_1008, 2'b00);
    checkSlot("reset_s2", 2, 1'b0, 32'h0000_100C, 2'b00);
    checkSlot("reset_s3", 3, 1'b0, 32'h0000_1010, 2'b00);

    resetn = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      if (n == 5) checkOutput("sweep_hit", 32'(hit), 32'd0);
      if (n == 31) begin
        update_pc = 32'h0000_1008; update_bta = 32'h0000_9999; update_type = 2'b01;
        update_en = 1'b1;
      end
      tick();
      update_en = 1'b0;
      n++;
    end
    checkOutput("init_sweep_len", 32'(n), 32'd32);
    applyStimulus(32'h0000_1000, 1'b1, 4'b0000);
    checkOutput("dropped_update_hit", 32'(hit), 32'd0);

    doUpdate(32'h0000_1008, 32'h0000_2000, 2'b01);
    checkOutput("upd_hitvec", 32'(hit), 32'h4);
    checkSlot("upd_s2", 2, 1'b1, 32'h0000_2000, 2'b01);
    checkSlot("upd_s0", 0, 1'b0, 32'h0000_1004, 2'b00);
    checkSlot("upd_s1", 1, 1'b0, 32'h0000_1008, 2'b00);
    checkSlot("upd_s3", 3, 1'b0, 32'h0000_1010, 2'b00);
    applyStimulus(32'h0000_1000, 1'b0, 4'b0000);
    checkOutput("nolv_hit", 32'(hit), 32'd0);

    doUpdate(32'h0000_3008, 32'h0000_3333, 2'b00);
    applyStimulus(32'h0000_1000, 1'b1, 4'b0100);
    tick();
    applyStimulus(32'h0000_3000, 1'b1, 4'b0000);
    checkSlot("fill_3008", 2, 1'b1, 32'h0000_3333, 2'b00);
    doUpdate(32'h0000_5008, 32'h0000_5555, 2'b11);
    applyStimulus(32'h0000_1000, 1'b1, 4'b0000);
    checkSlot("lru_keep_1008", 2, 1'b1, 32'h0000_2000, 2'b01);
    applyStimulus(32'h0000_5000, 1'b1, 4'b0000);
    checkSlot("lru_new_5008", 2, 1'b1, 32'h0000_5555, 2'b11);
    applyStimulus(32'h0000_3000, 1'b1, 4'b0000);
    checkSlot("lru_evict_3008", 2, 1'b0, 32'h0000_300C, 2'b00);

    doUpdate(32'h0000_1018, 32'h0000_2000, 2'b00);
    doUpdate(32'h0000_1018, 32'h0000_4000, 2'b10);
    applyStimulus(32'h0000_1010, 1'b1, 4'b0000);
    checkSlot("overwrite", 2, 1'b1, 32'h0000_4000, 2'b10);
    doUpdate(32'h0000_3018, 32'h0000_6000, 2'b00);
    applyStimulus(32'h0000_1010, 1'b1, 4'b0000);
    checkSlot("fill_keep", 2, 1'b1, 32'h0000_4000, 2'b10);
    applyStimulus(32'h0000_3010, 1'b1, 4'b0000);
    checkSlot("fill_new", 2, 1'b1, 32'h0000_6000, 2'b00);

    applyStimulus(32'h0000_1030, 1'b1, 4'b0000);
    update_pc = 32'h0000_1038; update_bta = 32'h0000_7700; update_type = 2'b01; update_en = 1'b1;
    checkSlot("same_cyc_old", 2, 1'b0, 32'h0000_103C, 2'b00);
    tick();
    update_en = 1'b0;
    checkSlot("same_cyc_new", 2, 1'b1, 32'h0000_7700, 2'b01);

    doUpdate(32'h0000_3028, 32'h0000_A000, 2'b00);
    applyStimulus(32'h0000_3020, 1'b1, 4'b0100);
    update_pc = 32'h0000_1028; update_bta = 32'h0000_7000; update_type = 2'b01; update_en = 1'b1;
    checkSlot("touch_old", 2, 1'b1, 32'h0000_A000, 2'b00);
    tick();
    update_en = 1'b0;
    applyStimulus(32'h0000_1020, 1'b1, 4'b0000);
    checkSlot("touch_new", 2, 1'b1, 32'h0000_7000, 2'b01);
    doUpdate(32'h0000_5028, 32'h0000_B000, 2'b11);
    applyStimulus(32'h0000_3020, 1'b1, 4'b0000);
    checkSlot("upd_mru_evict", 2, 1'b0, 32'h0000_302C, 2'b00);
    applyStimulus(32'h0000_1020, 1'b1, 4'b0000);
    checkSlot("upd_mru_keep", 2, 1'b1, 32'h0000_7000, 2'b01);
    applyStimulus(32'h0000_5020, 1'b1, 4'b0000);
    checkSlot("upd_mru_new", 2, 1'b1, 32'h0000_B000, 2'b11);

    applyStimulus(32'h0000_1000, 1'b1, 4'b0000);
    flush = 1'b1;
    checkSlot("flush_cycle", 2, 1'b1, 32'h0000_2000, 2'b01);
    tick();
    flush = 1'b0;
    checkOutput("flush_ready", 32'(ready), 32'd0);
    countSweep(n);
    checkOutput("flush_sweep_len", 32'(n), 32'd32);
    applyStimulus(32'h0000_1000, 1'b1, 4'b0000);
    checkSlot("flushed_1008", 2, 1'b0, 32'h0000_100C, 2'b00);
    applyStimulus(32'h0000_5000, 1'b1, 4'b0000);
    checkSlot("flushed_5008", 2, 1'b0, 32'h0000_500C, 2'b00);
    applyStimulus(32'h0000_1010, 1'b1, 4'b0000);
    checkSlot("flushed_1018", 2, 1'b0, 32'h0000_101C, 2'b00);

    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (9) tick();
    checkOutput("reflush_ready", 32'(ready), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    countSweep(n);
    checkOutput("reflush_sweep_len", 32'(n), 32'd32);

    doUpdate(32'h0000_1008, 32'h0000_1234, 2'b10);
    applyStimulus(32'h0000_1000, 1'b1, 4'b0000);
    checkSlot("post_flush_upd", 2, 1'b1, 32'h0000_1234, 2'b10);

    applyStimulus(32'hFFFF_FFF0, 1'b1, 4'b0000);
    checkSlot("wrap_s3", 3, 1'b0, 32'h0000_0000, 2'b00);
    checkSlot("wrap_s0", 0, 1'b0, 32'hFFFF_FFF4, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
